// File: rtl/gen_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gen_register_pkg
//  Description : Shared types for gen_register: op codes, FSM states and
//                rotate direction.
//  Revision    : 1.0  initial release
// ============================================================================
package gen_register_pkg;

    // Width of the encoded op field
    localparam int c_OP_W = 3;

    // Operation codes presented on the op port
    typedef enum logic [c_OP_W-1:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ROR_N = 3'd6,
        OP_ROL_N = 3'd7
    } gen_reg_op_e;

    // Control FSM: IDLE accepts ops, ROT walks a multi-cycle rotate
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ROT  = 1'b1
    } gen_reg_state_e;

    // Direction of a single rotate step
    typedef enum logic [0:0] {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } gen_reg_dir_e;

endpackage : gen_register_pkg
`default_nettype wire

// File: rtl/gen_register_alu.sv
`default_nettype none
// ============================================================================
//  Module      : gen_register_alu
//  Description : Combinational one-step datapath for gen_register. Produces
//                the next register value and carry for a single op. The
//                multi-cycle rotate ops (ROR_N/ROL_N) perform one step in
//                the direction given on dir_i.
//                Build option: SATURATE_EN makes INC/DEC hold at the
//                all-ones / zero boundary instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module gen_register_alu
    import gen_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             carry_i,
    input  gen_reg_op_e      op_i,
    input  gen_reg_dir_e     dir_i,
    output logic [WIDTH-1:0] q_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] w_ror_q;
    logic [WIDTH-1:0] w_rol_q;
    logic [WIDTH-1:0] w_inc_q;
    logic [WIDTH-1:0] w_dec_q;
    logic             w_all_ones;
    logic             w_all_zero;

    assign w_ror_q    = {q_i[0], q_i[WIDTH-1:1]};
    assign w_rol_q    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
    assign w_all_ones = &q_i;
    assign w_all_zero = ~|q_i;

`ifdef SATURATE_EN
    // Boundary values stick instead of wrapping; carry still flags the event
    assign w_inc_q = w_all_ones ? q_i : q_i + WIDTH'(1);
    assign w_dec_q = w_all_zero ? q_i : q_i - WIDTH'(1);
`else
    assign w_inc_q = q_i + WIDTH'(1);
    assign w_dec_q = q_i - WIDTH'(1);
`endif

    // Select the one-step result for the requested op
    always_comb begin
        q_o     = q_i;
        carry_o = carry_i;
        case (op_i)
            OP_HOLD: begin
                q_o     = q_i;
                carry_o = carry_i;
            end
            OP_LOAD: begin
                q_o     = d_i;
                carry_o = 1'b0;
            end
            OP_INC: begin
                q_o     = w_inc_q;
                carry_o = w_all_ones;
            end
            OP_DEC: begin
                q_o     = w_dec_q;
                carry_o = w_all_zero;
            end
            OP_ROR: begin
                q_o     = w_ror_q;
                carry_o = q_i[0];
            end
            OP_ROL: begin
                q_o     = w_rol_q;
                carry_o = q_i[WIDTH-1];
            end
            OP_ROR_N, OP_ROL_N: begin
                if (dir_i == DIR_LEFT) begin
                    q_o     = w_rol_q;
                    carry_o = q_i[WIDTH-1];
                end else begin
                    q_o     = w_ror_q;
                    carry_o = q_i[0];
                end
            end
            default: begin
                q_o     = q_i;
                carry_o = carry_i;
            end
        endcase
    end

endmodule : gen_register_alu
`default_nettype wire

// File: rtl/gen_register.sv
`default_nettype none
// ============================================================================
//  Module      : gen_register
//  Description : WIDTH-bit general-purpose counter/rotator with an encoded
//                op port and valid/ready handshake. Supports load, inc, dec,
//                single rotates and multi-cycle rotate-by-amt (one bit per
//                clock). Carry and zero status flags.
//                Build option: SATURATE_EN (INC/DEC saturate, see ALU).
//                WIDTH must be at least 2.
//  Revision    : 1.0  initial release
// ============================================================================
module gen_register
    import gen_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [c_OP_W-1:0] op,
    input  logic [AMT_W-1:0]  amt,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic              carry,
    output logic              zero,
    output logic              busy
);

    localparam logic [AMT_W-1:0] c_AMT_ONE = AMT_W'(1);

    gen_reg_state_e   r_state_q;
    gen_reg_state_e   w_state_d;
    logic [AMT_W-1:0] r_count_q;
    logic [AMT_W-1:0] w_count_d;
    gen_reg_dir_e     r_dir_q;
    gen_reg_dir_e     w_dir_d;
    logic [WIDTH-1:0] r_q_q;
    logic [WIDTH-1:0] w_q_d;
    logic             r_carry_q;
    logic             w_carry_d;

    gen_reg_op_e      w_op_in;
    logic             w_is_rot_n;
    logic             w_accept;
    logic             w_start_rot;
    gen_reg_op_e      w_alu_op;
    gen_reg_dir_e     w_alu_dir;
    logic [WIDTH-1:0] w_alu_q;
    logic             w_alu_carry;

    assign w_op_in     = gen_reg_op_e'(op);
    assign w_is_rot_n  = (w_op_in == OP_ROR_N) || (w_op_in == OP_ROL_N);
    assign w_accept    = op_valid && (r_state_q == IDLE);
    // Only rotates longer than one step need the ROT state
    assign w_start_rot = w_accept && w_is_rot_n && (amt > c_AMT_ONE);

    // Choose what the one-step datapath computes this cycle
    always_comb begin
        w_alu_op  = OP_HOLD;
        w_alu_dir = r_dir_q;
        if (r_state_q == ROT) begin
            // Inputs are ignored while rotating; keep stepping the latched way
            w_alu_op  = OP_ROR_N;
            w_alu_dir = r_dir_q;
        end else if (w_accept) begin
            w_alu_op = w_op_in;
            if (w_is_rot_n) begin
                w_alu_dir = (w_op_in == OP_ROL_N) ? DIR_LEFT : DIR_RIGHT;
                // A zero-length rotate is a pure no-op
                if (amt == '0) begin
                    w_alu_op = OP_HOLD;
                end
            end
        end
    end

    gen_register_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .q_i     (r_q_q),
        .d_i     (D),
        .carry_i (r_carry_q),
        .op_i    (w_alu_op),
        .dir_i   (w_alu_dir),
        .q_o     (w_alu_q),
        .carry_o (w_alu_carry)
    );

    // Next-state logic for the FSM, step counter and direction latch
    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        w_dir_d   = r_dir_q;
        w_q_d     = w_alu_q;
        w_carry_d = w_alu_carry;
        case (r_state_q)
            IDLE: begin
                if (w_start_rot) begin
                    // First step happens on the acceptance edge itself
                    w_dir_d   = w_alu_dir;
                    w_count_d = amt - c_AMT_ONE;
                    w_state_d = ROT;
                end
            end
            ROT: begin
                w_count_d = r_count_q - c_AMT_ONE;
                if (r_count_q == c_AMT_ONE) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_count_q <= '0;
            r_dir_q   <= DIR_RIGHT;
            r_q_q     <= '0;
            r_carry_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
            r_dir_q   <= w_dir_d;
            r_q_q     <= w_q_d;
            r_carry_q <= w_carry_d;
        end
    end

    assign Q        = r_q_q;
    assign carry    = r_carry_q;
    assign zero     = (r_q_q == '0);
    assign op_ready = (r_state_q == IDLE);
    assign busy     = (r_state_q == ROT);

endmodule : gen_register
`default_nettype wire
